// File: rtl/gpio_bank_pkg.sv
// Shared constants for the GPIO bank: register offsets, CTRL/STAT bit layout,
// default parameter values and the offset decoder.
package gpio_bank_pkg;

  localparam int unsigned DEF_GPIO_W   = 32;
  localparam int unsigned DEF_TMR_W    = 8;
  localparam int unsigned DEF_PRESCALE = 21;
  localparam int unsigned DEF_TMR_INIT = 32'h2F;
  localparam logic [11:0] DEF_BASE     = 12'h168;

  localparam logic [11:0] OFS_IN     = 12'h000;
  localparam logic [11:0] OFS_OUT    = 12'h004;
  localparam logic [11:0] OFS_CTRL   = 12'h008;
  localparam logic [11:0] OFS_RELOAD = 12'h00C;
  localparam logic [11:0] OFS_CHG    = 12'h010;
  localparam logic [11:0] OFS_CHGEN  = 12'h014;

  localparam int unsigned CTRL_INT_BIT = 0;
  localparam int unsigned CTRL_EN_BIT  = 1;
  localparam int unsigned CTRL_CNT_LSB = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_IN,
    SEL_OUT,
    SEL_CTRL,
    SEL_RELOAD,
    SEL_CHG,
    SEL_CHGEN
  } reg_sel_e;

  function automatic reg_sel_e decode_reg(input logic [11:0] off);
    case (off)
      OFS_IN:     return SEL_IN;
      OFS_OUT:    return SEL_OUT;
      OFS_CTRL:   return SEL_CTRL;
      OFS_RELOAD: return SEL_RELOAD;
      OFS_CHG:    return SEL_CHG;
      OFS_CHGEN:  return SEL_CHGEN;
      default:    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer with a third flop for edge detection; RISING selects
// rising-edge (1) or falling-edge (0) events.
module edge_sync #(
  parameter bit RISING = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic evt_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[1:0], async_i};
  end

  assign evt_o = RISING ? (sync_q[1] & ~sync_q[2]) : (~sync_q[1] & sync_q[2]);

endmodule

// File: rtl/gpio_bank.sv
// GPIO bank with asynchronous strobe bus interface, input capture with change
// detection, and a prescaled reload interval timer driving a level interrupt.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int unsigned GPIO_W   = DEF_GPIO_W,
  parameter int unsigned TMR_W    = DEF_TMR_W,
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned TMR_INIT = DEF_TMR_INIT,
  parameter logic [11:0] BASE     = DEF_BASE
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [15:0]       saddress,
  input  logic              srd,
  input  logic              swr,
  input  logic [31:0]       sdata_in,
  output logic [31:0]       sdata_out,
  input  logic [GPIO_W-1:0] gpio_in,
  input  logic              gpio_latch,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              irq
);

  localparam int unsigned PW = $clog2(PRESCALE);

  logic rd_evt, wr_evt, latch_evt;

  edge_sync #(.RISING(1'b0)) u_srd   (.clk_i(clk), .rst_ni(n_reset), .async_i(srd),        .evt_o(rd_evt));
  edge_sync #(.RISING(1'b0)) u_swr   (.clk_i(clk), .rst_ni(n_reset), .async_i(swr),        .evt_o(wr_evt));
  edge_sync #(.RISING(1'b1)) u_latch (.clk_i(clk), .rst_ni(n_reset), .async_i(gpio_latch), .evt_o(latch_evt));

  logic [GPIO_W-1:0] in_q, in_d, out_q, out_d, chg_q, chg_d, chgen_q, chgen_d;
  logic [TMR_W-1:0]  cnt_q, cnt_d, reload_q, reload_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              int_q, int_d, en_q, en_d, irq_q, irq_d;
  logic [31:0]       sdata_q, sdata_d, rdata;
  logic              tick, ctrl_clr;
  reg_sel_e          sel;
  logic              unused_addr;

  assign unused_addr = ^saddress[15:12];
  assign sel      = decode_reg(saddress[11:0] - BASE);
  assign tick     = en_q && (presc_q == PW'(PRESCALE - 1));
  assign ctrl_clr = wr_evt && (sel == SEL_CTRL) && sdata_in[CTRL_INT_BIT];

  always_comb begin
    in_d     = in_q;
    out_d    = out_q;
    chg_d    = chg_q;
    chgen_d  = chgen_q;
    reload_d = reload_q;
    en_d     = en_q;
    int_d    = int_q;
    cnt_d    = cnt_q;
    presc_d  = presc_q;

    if (wr_evt) begin
      case (sel)
        SEL_OUT:    out_d    = sdata_in[GPIO_W-1:0];
        SEL_CHGEN:  chgen_d  = sdata_in[GPIO_W-1:0];
        SEL_RELOAD: reload_d = sdata_in[TMR_W-1:0];
        SEL_CHG:    chg_d    = chg_q & ~sdata_in[GPIO_W-1:0];
        SEL_CTRL:   en_d     = sdata_in[CTRL_EN_BIT];
        default: ;
      endcase
    end

    // Newly detected changes are ORed in after the W1C so a coincident set wins.
    if (latch_evt) begin
      in_d  = gpio_in;
      chg_d = chg_d | (gpio_in ^ in_q);
    end

    // A clear from CTRL overrides any tick landing on the same edge.
    if (ctrl_clr) begin
      int_d   = 1'b0;
      cnt_d   = reload_q;
      presc_d = '0;
    end else if (en_q) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (cnt_q == '0) begin
          cnt_d = reload_q;
          int_d = 1'b1;
        end else begin
          cnt_d = cnt_q - TMR_W'(1);
        end
      end
    end
  end

  // Read data is taken from next-state values so a coincident write reads back.
  always_comb begin
    rdata = '0;
    case (sel)
      SEL_IN:     rdata[GPIO_W-1:0] = in_d;
      SEL_OUT:    rdata[GPIO_W-1:0] = out_d;
      SEL_CHG:    rdata[GPIO_W-1:0] = chg_d;
      SEL_CHGEN:  rdata[GPIO_W-1:0] = chgen_d;
      SEL_RELOAD: rdata[TMR_W-1:0]  = reload_d;
      SEL_CTRL: begin
        rdata[CTRL_INT_BIT]            = int_d;
        rdata[CTRL_EN_BIT]             = en_d;
        rdata[CTRL_CNT_LSB +: TMR_W]   = cnt_d;
      end
      default: ;
    endcase
  end

  assign sdata_d = rd_evt ? rdata : sdata_q;
  assign irq_d   = int_q | (|(chg_q & chgen_q));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      in_q     <= '0;
      out_q    <= '0;
      chg_q    <= '0;
      chgen_q  <= '0;
      reload_q <= TMR_W'(TMR_INIT);
      cnt_q    <= TMR_W'(TMR_INIT);
      presc_q  <= '0;
      en_q     <= 1'b1;
      int_q    <= 1'b0;
      irq_q    <= 1'b0;
      sdata_q  <= '0;
    end else begin
      in_q     <= in_d;
      out_q    <= out_d;
      chg_q    <= chg_d;
      chgen_q  <= chgen_d;
      reload_q <= reload_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
      en_q     <= en_d;
      int_q    <= int_d;
      irq_q    <= irq_d;
      sdata_q  <= sdata_d;
    end
  end

  assign sdata_out = sdata_q;
  assign gpio_out  = out_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank with default parameters.
module tb_gpio_bank;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] saddress = '0;
  logic        srd = 1'b1;
  logic        swr = 1'b1;
  logic [31:0] sdata_in = '0;
  logic [31:0] sdata_out;
  logic [31:0] gpio_in = '0;
  logic        gpio_latch = 1'b0;
  logic [31:0] gpio_out;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  localparam logic [15:0] A_IN = 16'h0168, A_OUT = 16'h016C, A_CTRL = 16'h0170,
                          A_RELOAD = 16'h0174, A_CHG = 16'h0178, A_CHGEN = 16'h017C;

  gpio_bank dut (
    .clk(clk), .n_reset(n_reset), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .gpio_in(gpio_in),
    .gpio_latch(gpio_latch), .gpio_out(gpio_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    saddress = a; sdata_in = d; swr = 1'b0;
    clk_n(4);
    swr = 1'b1;
    clk_n(3);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    saddress = a; srd = 1'b0;
    clk_n(4);
    d = sdata_out;
    srd = 1'b1;
    clk_n(3);
  endtask

  task automatic do_latch(input logic [31:0] v);
    gpio_in = v;
    clk_n(1);
    gpio_latch = 1'b1;
    clk_n(4);
    gpio_latch = 1'b0;
    clk_n(3);
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    clk_n(2);
    n_reset = 1'b1;
    clk_n(1);
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    clk_n(2);
    checks++; if (sdata_out !== 32'h0) begin errors++; $display("FAIL rst_sdata: got %h expected %h", sdata_out, 32'h0); end
    checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL rst_gpio_out: got %h expected %h", gpio_out, 32'h0); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq); end
    n_reset = 1'b1;
    clk_n(1);
    bus_read(A_CTRL, rd);
    checks++; if (rd !== 32'h0000_2F02) begin errors++; $display("FAIL rst_ctrl: got %h expected %h", rd, 32'h0000_2F02); end
    bus_read(A_RELOAD, rd);
    checks++; if (rd !== 32'h0000_002F) begin errors++; $display("FAIL rst_reload: got %h expected %h", rd, 32'h2F); end
    bus_read(A_IN, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_in: got %h expected %h", rd, 32'h0); end
  endtask

  task automatic test_out_rw();
    bus_write(A_OUT, 32'hA5A5_A5A5);
    bus_read(A_OUT, rd);
    checks++; if (rd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL out_read: got %h expected %h", rd, 32'hA5A5_A5A5); end
    checks++; if (gpio_out !== 32'hA5A5_A5A5) begin errors++; $display("FAIL out_pins: got %h expected %h", gpio_out, 32'hA5A5_A5A5); end
    bus_write(A_OUT, 32'h0);
    checks++; if (sdata_out !== 32'hA5A5_A5A5) begin errors++; $display("FAIL rdata_hold: got %h expected %h", sdata_out, 32'hA5A5_A5A5); end
    bus_read(16'h0180, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected %h", rd, 32'h0); end
    bus_write(A_IN, 32'hFFFF_FFFF);
    bus_read(A_IN, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL in_ro: got %h expected %h", rd, 32'h0); end
  endtask

  task automatic test_rd_wr_same();
    saddress = A_OUT; sdata_in = 32'h1234_5678;
    srd = 1'b0; swr = 1'b0;
    clk_n(4);
    checks++; if (sdata_out !== 32'h1234_5678) begin errors++; $display("FAIL rdwr_data: got %h expected %h", sdata_out, 32'h1234_5678); end
    checks++; if (gpio_out !== 32'h1234_5678) begin errors++; $display("FAIL rdwr_pins: got %h expected %h", gpio_out, 32'h1234_5678); end
    srd = 1'b1; swr = 1'b1;
    clk_n(3);
  endtask

  task automatic test_timer();
    do_reset();
    clk_n(48 * 21 + 5);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tmr_irq_set: got %b expected 1", irq); end
    bus_read(A_CTRL, rd);
    checks++; if (rd[0] !== 1'b1) begin errors++; $display("FAIL tmr_int_set: got %b expected 1", rd[0]); end
    saddress = A_CTRL; sdata_in = 32'h3; swr = 1'b0;
    clk_n(3);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL tmr_irq_lag: got %b expected 1", irq); end
    clk_n(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tmr_irq_clr: got %b expected 0", irq); end
    swr = 1'b1;
    clk_n(3);
    bus_read(A_CTRL, rd);
    checks++; if (rd !== 32'h0000_2F02) begin errors++; $display("FAIL tmr_ctrl_clr: got %h expected %h", rd, 32'h0000_2F02); end
  endtask

  task automatic test_chg();
    bus_write(A_CTRL, 32'h1);
    do_latch(32'h0F);
    bus_write(A_CHG, 32'hFFFF_FFFF);
    do_latch(32'h3C);
    bus_read(A_IN, rd);
    checks++; if (rd !== 32'h3C) begin errors++; $display("FAIL chg_in: got %h expected %h", rd, 32'h3C); end
    bus_read(A_CHG, rd);
    checks++; if (rd !== 32'h33) begin errors++; $display("FAIL chg_val: got %h expected %h", rd, 32'h33); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL chg_irq_masked: got %b expected 0", irq); end
    bus_write(A_CHGEN, 32'h1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL chg_irq_en: got %b expected 1", irq); end
    bus_write(A_CHG, 32'h1);
    bus_read(A_CHG, rd);
    checks++; if (rd !== 32'h32) begin errors++; $display("FAIL chg_w1c: got %h expected %h", rd, 32'h32); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL chg_irq_w1c: got %b expected 0", irq); end
    bus_read(A_CTRL, rd);
    checks++; if (rd !== 32'h0000_2F00) begin errors++; $display("FAIL tmr_frozen: got %h expected %h", rd, 32'h0000_2F00); end
  endtask

  task automatic test_w1c_vs_latch();
    gpio_in = 32'h3D;
    clk_n(1);
    saddress = A_CHG; sdata_in = 32'hFFFF_FFFF;
    swr = 1'b0; gpio_latch = 1'b1;
    clk_n(4);
    swr = 1'b1; gpio_latch = 1'b0;
    clk_n(3);
    bus_read(A_CHG, rd);
    checks++; if (rd !== 32'h01) begin errors++; $display("FAIL w1c_latch_chg: got %h expected %h", rd, 32'h01); end
    bus_read(A_IN, rd);
    checks++; if (rd !== 32'h3D) begin errors++; $display("FAIL w1c_latch_in: got %h expected %h", rd, 32'h3D); end
    bus_write(A_CHG, 32'hFFFF_FFFF);
  endtask

  task automatic test_tick_clear();
    // First clear lands 3 edges after swr falls; the 48th tick after it lands 1008 edges later.
    saddress = A_CTRL; sdata_in = 32'h3; swr = 1'b0;
    clk_n(5);
    swr = 1'b1;
    clk_n(1003);
    swr = 1'b0;
    clk_n(4);
    swr = 1'b1;
    clk_n(3);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL tick_clr_irq: got %b expected 0", irq); end
    bus_read(A_CTRL, rd);
    checks++; if (rd !== 32'h0000_2F02) begin errors++; $display("FAIL tick_clr_ctrl: got %h expected %h", rd, 32'h0000_2F02); end
  endtask

  task automatic test_reset_mid_write();
    bus_write(A_OUT, 32'h5A5A_5A5A);
    checks++; if (gpio_out !== 32'h5A5A_5A5A) begin errors++; $display("FAIL mid_pre: got %h expected %h", gpio_out, 32'h5A5A_5A5A); end
    saddress = A_OUT; sdata_in = 32'hDEAD_BEEF; swr = 1'b0;
    clk_n(1);
    n_reset = 1'b0;
    clk_n(2);
    checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL mid_rst: got %h expected %h", gpio_out, 32'h0); end
    n_reset = 1'b1;
    clk_n(5);
    swr = 1'b1;
    clk_n(5);
    checks++; if (gpio_out !== 32'h0) begin errors++; $display("FAIL mid_release: got %h expected %h", gpio_out, 32'h0); end
    bus_read(A_OUT, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL mid_read: got %h expected %h", rd, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_out_rw();
    test_rd_wr_same();
    test_timer();
    test_chg();
    test_w1c_vs_latch();
    test_tick_clear();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_bank.md
GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 Parameter GPIO_W, default 32: width of the GPIO input and output ports, 4..32.
REQ-002 Parameter TMR_W, default 8: interval timer width.
REQ-003 Parameter PRESCALE, default 21: clk cycles per timer tick, at least 2.
REQ-004 Parameter TMR_INIT, default 8'h2F (zero-extended to TMR_W): reset value of RELOAD.
REQ-005 Parameter BASE, default 12'h168: register-window base offset.
REQ-006 Port clk, input, 1: single clock; one clock; reset is asynchronous and active-low.
REQ-007 Port n_reset, input, 1: asynchronous active-low reset.
REQ-008 Port saddress, input, 16: bus address; only [11:0] decoded; stable while a strobe is low.
REQ-009 Port srd, input, 1: active-low read strobe, asynchronous to clk.
REQ-010 Port swr, input, 1: active-low write strobe, asynchronous to clk.
REQ-011 Port sdata_in, input, 32: write data.
REQ-012 Port sdata_out, output, 32: registered read data.
REQ-013 Port gpio_in, input, GPIO_W: external inputs.
REQ-014 Port gpio_latch, input, 1: asynchronous capture strobe, rising-edge active.
REQ-015 Port gpio_out, output, GPIO_W: output register.
REQ-016 Port irq, output, 1: level interrupt request.

Function
REQ-017 srd, swr and gpio_latch each pass through a 2-FF synchronizer; an event is a falling edge (srd, swr) or rising edge (gpio_latch) between the second and third flops.
REQ-018 Register map at offsets BASE+: 0x00 IN (RO), 0x04 OUT (RW), 0x08 CTRL/STAT, 0x0C RELOAD (RW), 0x10 CHG (RO, write-1-to-clear), 0x14 CHG_EN (RW).
REQ-019 A read event loads sdata_out on the next clk edge: the register value, zero-extended to 32 bits; unmapped offsets read 0.
REQ-020 sdata_out holds its value until the next read event.
REQ-021 A write event updates the addressed register on the same clk edge; bits above GPIO_W and TMR_W are ignored; writes to RO or unmapped offsets have no effect.
REQ-022 A gpio_latch event captures gpio_in into IN and ORs (gpio_in XOR IN-old) into CHG.
REQ-023 Prescaler counts 0..PRESCALE-1 and wraps; it emits a one-cycle tick at the terminal count.
REQ-024 On a tick with CNT != 0: CNT decrements by 1.
REQ-025 On a tick with CNT == 0: CNT reloads from RELOAD and STAT.INT sets.
REQ-026 CTRL/STAT read: bit0 INT, bit1 EN, bits[TMR_W+7:8] CNT.
REQ-027 CTRL/STAT write: bit1 sets EN.
REQ-028 CTRL/STAT write with bit0=1: clears INT, reloads CNT from RELOAD, and zeroes the prescaler.
REQ-029 With EN=0, the prescaler and CNT freeze and INT holds.
REQ-030 A CTRL/STAT write with bit0=1 on the same cycle as a tick takes priority; the tick is discarded.
REQ-031 A CHG write-1-to-clear on the same cycle as a latch event: newly detected bits set (set wins).
REQ-032 A read event and a write event on the same cycle: the write is applied first, and the read returns the new value.
REQ-033 irq = INT OR (|(CHG AND CHG_EN)), registered, one cycle after the source changes.

Reset
REQ-034 n_reset low asynchronously clears: IN, OUT, CHG, CHG_EN, sdata_out, INT, the prescaler and all synchronizer flops.
REQ-035 n_reset low asynchronously sets: CNT=TMR_INIT, RELOAD=TMR_INIT, EN=1; irq=0.
REQ-036 Reset asserted mid-access aborts the access; no register is partially updated.

Structure
REQ-037 Shared package gpio_bank_pkg holds the register offset constants, the CTRL bit indices and the default parameter values.
REQ-038 One sub-module, edge_sync (2-FF synchronizer plus edge detect, polarity parameter), is instantiated three times.

Verification
REQ-039 Reset, then read 0x170 (CTRL) -> sdata_out=32'h0000_2F02; gpio_out=0; irq=0.
REQ-040 Write 0x16C=32'hA5A5_A5A5, then read 0x16C -> 32'hA5A5_A5A5; gpio_out=32'hA5A5_A5A5.
REQ-041 Free run for 48*21 cycles -> INT=1 and irq=1; write CTRL=32'h3 -> INT=0, CNT=8'h2F, irq=0 two cycles after the write event.
REQ-042 gpio_in=0x0F, latch, then gpio_in=0x3C, latch -> IN=0x3C, CHG=0x33; with CHG_EN=0x01, irq=1; W1C 0x01 -> irq=0 and CHG=0x32.
REQ-043 Force a CTRL clear coincident with a tick at CNT=0 -> INT stays 0 and CNT=8'h2F.
REQ-044 Assert n_reset mid-write to OUT -> OUT=0 and no update after release.
